multicycle_sequencer: RTL

//  Parametrised multi-cycle control sequencer for the CPU datapath. Steps each instruction through

---
 rtl/multicycle_sequencer.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer
//   Multi-cycle control sequencer for the CPU datapath. Each instruction steps
//   through FETCH/DECODE/EXEC/MEM/WB. The block owns the PC and IR, handshakes
//   with instruction and data memory (request held until ack, with a timeout
//   into FAULT), and counts retired instructions.
//
//   Opcode classes (oIR[31:27]):
//     00000 LOAD, 00010 STORE, 10010 BRANCH, 11010 NOP, 11011 HALT, else ALU.
//
//   state  | meaning
//   FETCH  | oIMemReq held until iIMemAck, IR loaded on ack
//   DECODE | one cycle, load RA/RB
//   EXEC   | one cycle, load RZ, resolve branch target
//   MEM    | LOAD/STORE handshake, or one-cycle RY load for ALU ops
//   WB     | one cycle, rf write (ALU/LOAD), PC update, retire count
//   HALT   | sticky after HALT opcode, left only by reset
//   FAULT  | sticky after a memory timeout, PC holds faulting address
//
// Ports
//   iClk, iRst                     clock, synchronous active-high reset
//   oIMemReq/oIMemAddr/iIMemAck    instruction fetch handshake
//   iInstr, oIR, oPC               instruction word, IR, program counter
//   iBranchTaken, iBranchTgt       branch resolution, sampled in EXEC
//   oRegABEn, oRzEn, oRyEn         datapath register load strobes
//   oDMemRead/oDMemWrite/iDMemAck  data memory handshake
//   oRfWrite                       register file write strobe
//   oStage                         current state code (0..6)
//   oRetired                       retired instruction count

module multicycle_sequencer #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                TIMEOUT  = 15,
    parameter int                CNT_W    = 32
) (
    input  logic              iClk,
    input  logic              iRst,
    output logic              oIMemReq,
    output logic [ADDR_W-1:0] oIMemAddr,
    input  logic              iIMemAck,
    input  logic [DATA_W-1:0] iInstr,
    output logic [DATA_W-1:0] oIR,
    output logic [ADDR_W-1:0] oPC,
    input  logic              iBranchTaken,
    input  logic [ADDR_W-1:0] iBranchTgt,
    output logic              oRegABEn,
    output logic              oRzEn,
    output logic              oDMemRead,
    output logic              oDMemWrite,
    input  logic              iDMemAck,
    output logic              oRyEn,
    output logic              oRfWrite,
    output logic [2:0]        oStage,
    output logic [CNT_W-1:0]  oRetired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t             state, state_nxt;
    logic [7:0]         wait_cnt;
    logic [ADDR_W-1:0]  pc, next_pc;
    logic [DATA_W-1:0]  ir;
    logic [CNT_W-1:0]   retired;

    logic [4:0] opcode;
    logic       is_load, is_store, is_branch, is_nop, is_halt, is_alu, is_ldst;
    logic       timed_out, waiting;

    assign opcode    = ir[31:27];
    assign is_load   = (opcode == 5'b00000);
    assign is_store  = (opcode == 5'b00010);
    assign is_branch = (opcode == 5'b10010);
    assign is_nop    = (opcode == 5'b11010);
    assign is_halt   = (opcode == 5'b11011);
    assign is_ldst   = is_load | is_store;
    assign is_alu    = ~(is_ldst | is_branch | is_nop | is_halt);
    assign timed_out = (wait_cnt == TIMEOUT_CNT);

    // Only the two handshake states accumulate wait cycles.
    assign waiting = (state == S_FETCH) || (state == S_MEM && is_ldst);

    // State register and wait counter
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt != state)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
        end
    end

    // Next-state logic; an ack in the expiry cycle takes priority over FAULT.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_FETCH: begin
                if (iIMemAck)
                    state_nxt = S_DECODE;
                else if (timed_out)
                    state_nxt = S_FAULT;
            end
            S_DECODE: begin
                if (is_halt)
                    state_nxt = S_HALT;
                else if (is_nop)
                    state_nxt = S_WB;
                else
                    state_nxt = S_EXEC;
            end
            S_EXEC: begin
                state_nxt = is_branch ? S_WB : S_MEM;
            end
            S_MEM: begin
                if (!is_ldst || iDMemAck)
                    state_nxt = S_WB;
                else if (timed_out)
                    state_nxt = S_FAULT;
            end
            S_WB:    state_nxt = S_FETCH;
            S_HALT:  state_nxt = S_HALT;
            S_FAULT: state_nxt = S_FAULT;
            default: state_nxt = S_FAULT;
        endcase
    end

    // Strobes are forced low while reset is asserted.
    always_comb begin
        oIMemReq   = 1'b0;
        oRegABEn   = 1'b0;
        oRzEn      = 1'b0;
        oDMemRead  = 1'b0;
        oDMemWrite = 1'b0;
        oRyEn      = 1'b0;
        oRfWrite   = 1'b0;
        if (!iRst) begin
            unique case (state)
                S_FETCH:  oIMemReq = 1'b1;
                S_DECODE: oRegABEn = 1'b1;
                S_EXEC:   oRzEn    = 1'b1;
                S_MEM: begin
                    oDMemRead  = is_load;
                    oDMemWrite = is_store;
                    oRyEn      = is_alu | (is_load & iDMemAck);
                end
                S_WB:     oRfWrite = is_alu | is_load;
                default: ;
            endcase
        end
    end

    // PC, IR and retire counter. next_pc defaults to pc+4 in DECODE so NOP,
    // which skips EXEC, still advances sequentially.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            pc      <= RESET_PC;
            next_pc <= RESET_PC;
            ir      <= '0;
            retired <= '0;
        end else begin
            if (state == S_FETCH && iIMemAck)
                ir <= iInstr;
            if (state == S_DECODE)
                next_pc <= pc + ADDR_W'(4);
            if (state == S_EXEC && is_branch && iBranchTaken)
                next_pc <= iBranchTgt;
            if (state == S_WB) begin
                pc      <= next_pc;
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign oPC       = pc;
    assign oIMemAddr = pc;
    assign oIR       = ir;
    assign oRetired  = retired;
    assign oStage    = state;

endmodule
